// File: rtl/icache_pkg.sv
// Shared types and constants for the set-associative instruction cache.
// Holds the miss FSM state encoding and the RV32 opcodes that the predecoder recognises.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } icache_state_e;

  localparam logic [6:0] RV32_JAL_OP  = 7'h6F;
  localparam logic [6:0] RV32_JALR_OP = 7'h67;

  // x1 (ra) and x5 (t0) are the link registers used for return-address stack hints.
  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/icache_predecode.sv
// Combinational return-address-stack hint decoder for one 32-bit instruction word.
// A JAL/JALR writing a link register pushes; a JALR reading a different link register pops.
module icache_predecode
  import icache_pkg::*;
(
  input  logic [31:0] i_word,
  output logic        o_push,
  output logic        o_pop
);

  logic [6:0] w_op;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic       w_rd_link;
  logic       w_rs1_link;
  logic       w_unused;

  assign w_op       = i_word[6:0];
  assign w_rd       = i_word[11:7];
  assign w_rs1      = i_word[19:15];
  assign w_rd_link  = is_link_reg(w_rd);
  assign w_rs1_link = is_link_reg(w_rs1);
  assign w_unused   = ^{i_word[31:20], i_word[14:12]};

  always_comb begin
    o_push = 1'b0;
    o_pop  = 1'b0;
    if (w_op == RV32_JAL_OP) begin
      o_push = w_rd_link;
    end else if (w_op == RV32_JALR_OP) begin
      o_push = w_rd_link;
      // Same link register on both sides is a plain call, not a coroutine swap.
      o_pop  = w_rs1_link && (!w_rd_link || (w_rd != w_rs1));
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: 0-cycle lookup, true-LRU, single-outstanding 64-bit block miss FSM.
// Define ICACHE_PREDECODE_EN to store per-word RAS push/pop hints and expose o_ras_push/o_ras_pop.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int NUM_SETS    = 32,
  parameter int NUM_WAYS    = 2,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic [31:0]                          i_pc,
  input  logic                                 i_pc_valid,
  input  logic                                 i_flush,
  input  logic [31:0]                          i_prefetch_pc_check,
  output logic [FETCH_WIDTH-1:0][31:0]         o_instr,
  output logic [$clog2(FETCH_WIDTH+1)-1:0]     o_num_valid_instr,
  output logic                                 o_prefetch_pc_is_in_cache,
  output logic                                 o_busy,
  output logic                                 o_mem_req_valid,
  input  logic                                 i_mem_req_ready,
  output logic [31:0]                          o_mem_req_addr,
  input  logic                                 i_mem_rsp_valid,
  input  logic [63:0]                          i_mem_rsp_data
`ifdef ICACHE_PREDECODE_EN
  ,
  output logic [FETCH_WIDTH-1:0]               o_ras_push,
  output logic [FETCH_WIDTH-1:0]               o_ras_pop
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 29 - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int NV_W  = $clog2(FETCH_WIDTH + 1);

  logic [NUM_WAYS-1:0] r_valid    [NUM_SETS];
  logic [TAG_W-1:0]    r_tag      [NUM_SETS][NUM_WAYS];
  logic [63:0]         r_data     [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    r_age      [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    w_age_next [NUM_SETS][NUM_WAYS];

  icache_state_e r_state;
  icache_state_e w_state_next;
  logic [31:3]   r_miss_blk;

  logic [31:3]            w_lane_blk [FETCH_WIDTH];
  logic [IDX_W-1:0]       w_lane_set [FETCH_WIDTH];
  logic [WAY_W-1:0]       w_lane_way [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] w_lane_sel;
  logic [FETCH_WIDTH-1:0] w_lane_hit;

  logic [NV_W-1:0]  w_num_valid;
  logic             w_run;
  logic             w_miss_found;
  logic [31:3]      w_miss_blk;
  logic             w_fill;
  logic [IDX_W-1:0] w_fill_set;
  logic [TAG_W-1:0] w_fill_tag;
  logic [WAY_W-1:0] w_victim;
  logic [WAY_W-1:0] w_max_age;
  logic             w_inv_found;
  logic             w_dup;
  logic [WAY_W-1:0] w_ref_age;
  logic [IDX_W-1:0] w_probe_set;
  logic [TAG_W-1:0] w_probe_tag;
  logic             w_unused;

  assign w_unused = ^{i_pc[1:0], i_prefetch_pc_check[2:0]};

  genvar gi, gj;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
      logic [31:2]         w_word_addr;
      logic [TAG_W-1:0]    w_tag;
      logic [NUM_WAYS-1:0] w_way_hit;
      logic [63:0]         w_blk_data;

      assign w_word_addr    = i_pc[31:2] + 30'(gi);
      assign w_lane_blk[gi] = w_word_addr[31:3];
      assign w_lane_sel[gi] = w_word_addr[2];
      assign w_lane_set[gi] = w_word_addr[3+IDX_W-1:3];
      assign w_tag          = w_word_addr[31:3+IDX_W];

      for (gj = 0; gj < NUM_WAYS; gj++) begin : g_way
        assign w_way_hit[gj] = r_valid[w_lane_set[gi]][gj] &&
                               (r_tag[w_lane_set[gi]][gj] == w_tag);
      end

      assign w_lane_hit[gi] = i_pc_valid && (|w_way_hit);

      always_comb begin
        w_lane_way[gi] = '0;
        for (int v = NUM_WAYS - 1; v >= 0; v--) begin
          if (w_way_hit[v]) w_lane_way[gi] = WAY_W'(v);
        end
      end

      assign w_blk_data   = r_data[w_lane_set[gi]][w_lane_way[gi]];
      assign o_instr[gi]  = !w_lane_hit[gi] ? 32'd0 :
                            (w_lane_sel[gi] ? w_blk_data[63:32] : w_blk_data[31:0]);
    end
  endgenerate

  // Hit count is contiguous from lane 0; the first missing lane is the one to refill.
  always_comb begin
    w_num_valid  = '0;
    w_run        = 1'b1;
    w_miss_found = 1'b0;
    w_miss_blk   = w_lane_blk[0];
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      w_run = w_run & w_lane_hit[l];
      if (w_run) w_num_valid = w_num_valid + NV_W'(1);
      if (!w_lane_hit[l] && !w_miss_found) begin
        w_miss_blk   = w_lane_blk[l];
        w_miss_found = 1'b1;
      end
    end
  end
  assign o_num_valid_instr = w_num_valid;

  assign w_probe_set = i_prefetch_pc_check[3+IDX_W-1:3];
  assign w_probe_tag = i_prefetch_pc_check[31:3+IDX_W];
  always_comb begin
    o_prefetch_pc_is_in_cache = 1'b0;
    for (int v = 0; v < NUM_WAYS; v++) begin
      if (r_valid[w_probe_set][v] && (r_tag[w_probe_set][v] == w_probe_tag))
        o_prefetch_pc_is_in_cache = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_pc_valid && w_miss_found) w_state_next = REQ;
        REQ:     if (i_mem_req_ready) w_state_next = WAIT;
        WAIT:    if (i_mem_rsp_valid) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy          = (r_state != IDLE);
    o_mem_req_valid = (r_state == REQ);
    o_mem_req_addr  = {r_miss_blk, 3'b000};
    w_fill          = (r_state == WAIT) && i_mem_rsp_valid && !i_flush;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_miss_blk <= '0;
    else if ((r_state == IDLE) && (w_state_next == REQ))
      r_miss_blk <= w_miss_blk;
  end

  assign w_fill_set = r_miss_blk[3+IDX_W-1:3];
  assign w_fill_tag = r_miss_blk[31:3+IDX_W];

  // Victim: lowest invalid way, otherwise the oldest way in the set.
  always_comb begin
    w_victim    = '0;
    w_max_age   = r_age[w_fill_set][0];
    w_inv_found = 1'b0;
    for (int v = 1; v < NUM_WAYS; v++) begin
      if (r_age[w_fill_set][v] > w_max_age) begin
        w_max_age = r_age[w_fill_set][v];
        w_victim  = WAY_W'(v);
      end
    end
    for (int v = 0; v < NUM_WAYS; v++) begin
      if (!r_valid[w_fill_set][v] && !w_inv_found) begin
        w_victim    = WAY_W'(v);
        w_inv_found = 1'b1;
      end
    end
  end

  // Hits are applied lane by lane (one per distinct block); a fill overrides hit updates in its set.
  always_comb begin
    w_age_next = r_age;
    w_dup      = 1'b0;
    w_ref_age  = '0;
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      w_dup = 1'b0;
      for (int k = 0; k < l; k++) begin
        if (w_lane_hit[k] && (w_lane_blk[k] == w_lane_blk[l])) w_dup = 1'b1;
      end
      if (w_lane_hit[l] && !w_dup) begin
        w_ref_age = w_age_next[w_lane_set[l]][w_lane_way[l]];
        for (int v = 0; v < NUM_WAYS; v++) begin
          if (WAY_W'(v) == w_lane_way[l])
            w_age_next[w_lane_set[l]][v] = '0;
          else if (w_age_next[w_lane_set[l]][v] < w_ref_age)
            w_age_next[w_lane_set[l]][v] = w_age_next[w_lane_set[l]][v] + WAY_W'(1);
        end
      end
    end
    if (w_fill) begin
      w_ref_age = r_age[w_fill_set][w_victim];
      for (int v = 0; v < NUM_WAYS; v++) begin
        if (WAY_W'(v) == w_victim)
          w_age_next[w_fill_set][v] = '0;
        else if (r_age[w_fill_set][v] < w_ref_age)
          w_age_next[w_fill_set][v] = r_age[w_fill_set][v] + WAY_W'(1);
        else
          w_age_next[w_fill_set][v] = r_age[w_fill_set][v];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int v = 0; v < NUM_WAYS; v++)
          r_age[s][v] <= WAY_W'(v);
    end else begin
      r_age <= w_age_next;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      for (int s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
    end else if (w_fill) begin
      r_valid[w_fill_set][w_victim] <= 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_fill) begin
      r_data[w_fill_set][w_victim] <= i_mem_rsp_data;
      r_tag[w_fill_set][w_victim]  <= w_fill_tag;
    end
  end

`ifdef ICACHE_PREDECODE_EN
  logic [1:0] r_pd_push [NUM_SETS][NUM_WAYS];
  logic [1:0] r_pd_pop  [NUM_SETS][NUM_WAYS];
  logic [1:0] w_pd_push;
  logic [1:0] w_pd_pop;

  icache_predecode u_pd_word0 (
    .i_word (i_mem_rsp_data[31:0]),
    .o_push (w_pd_push[0]),
    .o_pop  (w_pd_pop[0])
  );

  icache_predecode u_pd_word1 (
    .i_word (i_mem_rsp_data[63:32]),
    .o_push (w_pd_push[1]),
    .o_pop  (w_pd_pop[1])
  );

  always_ff @(posedge i_clock) begin
    if (w_fill) begin
      r_pd_push[w_fill_set][w_victim] <= w_pd_push;
      r_pd_pop[w_fill_set][w_victim]  <= w_pd_pop;
    end
  end

  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_ras
      assign o_ras_push[gi] = w_lane_hit[gi] &&
                              r_pd_push[w_lane_set[gi]][w_lane_way[gi]][w_lane_sel[gi]];
      assign o_ras_pop[gi]  = w_lane_hit[gi] &&
                              r_pd_pop[w_lane_set[gi]][w_lane_way[gi]][w_lane_sel[gi]];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Directed self-checking bench for icache_assoc (default parameters: 32 sets, 2 ways, 2-wide fetch).
// Covers cold miss/fill, partial hit, stalled request, LRU eviction, flush corners and a lookup table.
module tb_icache_assoc;

  localparam int FW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [31:0]          pc;
  logic                 pc_valid;
  logic                 flush;
  logic [31:0]          probe;
  logic [FW-1:0][31:0]  instr;
  logic [1:0]           num_valid;
  logic                 probe_hit;
  logic                 busy;
  logic                 req_valid;
  logic                 req_ready;
  logic [31:0]          req_addr;
  logic                 rsp_valid;
  logic [63:0]          rsp_data;
`ifdef ICACHE_PREDECODE_EN
  logic [FW-1:0]        ras_push;
  logic [FW-1:0]        ras_pop;
`endif

  int checks = 0;
  int errors = 0;

  icache_assoc #(.NUM_SETS(32), .NUM_WAYS(2), .FETCH_WIDTH(FW)) dut (
    .i_clock                   (clk),
    .i_reset                   (rst),
    .i_pc                      (pc),
    .i_pc_valid                (pc_valid),
    .i_flush                   (flush),
    .i_prefetch_pc_check       (probe),
    .o_instr                   (instr),
    .o_num_valid_instr         (num_valid),
    .o_prefetch_pc_is_in_cache (probe_hit),
    .o_busy                    (busy),
    .o_mem_req_valid           (req_valid),
    .i_mem_req_ready           (req_ready),
    .o_mem_req_addr            (req_addr),
    .i_mem_rsp_valid           (rsp_valid),
    .i_mem_rsp_data            (rsp_data)
`ifdef ICACHE_PREDECODE_EN
    ,
    .o_ras_push                (ras_push),
    .o_ras_pop                 (ras_pop)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] probe;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  nv;
    logic        ph;
  } vec_t;

  vec_t vecs [7];

  localparam logic [63:0] D0 = 64'h00000011_00000010;
  localparam logic [63:0] D1 = 64'h00000021_00000020;
  localparam logic [63:0] D2 = 64'h00000031_00000030;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch a miss for blk_pc, accept the request and return data one cycle later.
  task automatic fill_block(input logic [31:0] fpc, input logic [31:0] exp_addr,
                            input logic [63:0] data, input string name);
    int n;
    @(negedge clk);
    pc       = fpc;
    pc_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!req_valid && n < 16);
    chk({name, "_req_seen"}, 64'(req_valid), 64'(1'b1));
    chk({name, "_req_addr"}, 64'(req_addr), 64'(exp_addr));
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = data;
    @(negedge clk);
    rsp_valid = 1'b0;
    pc_valid  = 1'b0;
    $display("fill %s addr=%h data=%h", name, exp_addr, data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h000, 1'b1, 32'h204, 32'h10, 32'h11, 2'd2, 1'b1};
    vecs[1] = '{32'h004, 1'b1, 32'h100, 32'h11, 32'h00, 2'd1, 1'b0};
    vecs[2] = '{32'h200, 1'b1, 32'h000, 32'h30, 32'h31, 2'd2, 1'b1};
    vecs[3] = '{32'h204, 1'b1, 32'h300, 32'h31, 32'h00, 2'd1, 1'b0};
    vecs[4] = '{32'h300, 1'b1, 32'h200, 32'h00, 32'h00, 2'd0, 1'b1};
    vecs[5] = '{32'h000, 1'b0, 32'h100, 32'h00, 32'h00, 2'd0, 1'b0};
    vecs[6] = '{32'h1FC, 1'b1, 32'h1F8, 32'h00, 32'h30, 2'd0, 1'b0};

    rst = 1'b1; pc = '0; pc_valid = 1'b0; flush = 1'b0; probe = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy",      64'(busy),      64'(1'b0));
    chk("rst_req_valid", 64'(req_valid), 64'(1'b0));
    chk("rst_req_addr",  64'(req_addr),  64'(32'h0));
    chk("rst_nv",        64'(num_valid), 64'(2'd0));
    chk("rst_instr",     64'(instr),     64'(64'h0));
    chk("rst_probe",     64'(probe_hit), 64'(1'b0));

    // Cold miss at 0x100
    @(negedge clk); pc = 32'h100; pc_valid = 1'b1; #1;
    chk("cold_nv", 64'(num_valid), 64'(2'd0));
    chk("cold_busy_idle", 64'(busy), 64'(1'b0));
    @(negedge clk); #1;
    chk("cold_busy", 64'(busy), 64'(1'b1));
    chk("cold_req_valid", 64'(req_valid), 64'(1'b1));
    chk("cold_req_addr", 64'(req_addr), 64'(32'h100));
    req_ready = 1'b1;
    @(negedge clk); req_ready = 1'b0; #1;
    chk("cold_wait_req_low", 64'(req_valid), 64'(1'b0));
    chk("cold_wait_busy", 64'(busy), 64'(1'b1));
    rsp_valid = 1'b1; rsp_data = 64'h0000000B_0000000A; #1;
    chk("cold_no_bypass_nv", 64'(num_valid), 64'(2'd0));
    @(negedge clk); rsp_valid = 1'b0; #1;
    chk("cold_after_busy", 64'(busy), 64'(1'b0));
    chk("cold_after_nv", 64'(num_valid), 64'(2'd2));
    chk("cold_after_i0", 64'(instr[0]), 64'(32'hA));
    chk("cold_after_i1", 64'(instr[1]), 64'(32'hB));
    $display("txn cold pc=100 nv=%0d", num_valid);

    // Partial hit at 0x104, then a stalled request for 0x108
    @(negedge clk); pc = 32'h104; #1;
    chk("part_nv", 64'(num_valid), 64'(2'd1));
    chk("part_i0", 64'(instr[0]), 64'(32'hB));
    chk("part_i1", 64'(instr[1]), 64'(32'h0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rsp_valid = (i == 2);
      rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      chk("stall_req_valid", 64'(req_valid), 64'(1'b1));
      chk("stall_req_addr", 64'(req_addr), 64'(32'h108));
      chk("stall_busy", 64'(busy), 64'(1'b1));
    end
    req_ready = 1'b1;
    @(negedge clk); req_ready = 1'b0; #1;
    chk("stall_wait_req_low", 64'(req_valid), 64'(1'b0));
    chk("stall_rsp_in_req_ignored", 64'(num_valid), 64'(2'd1));
    rsp_valid = 1'b1; rsp_data = 64'h0000000D_0000000C;
    @(negedge clk); rsp_valid = 1'b0; #1;
    chk("part_fill_nv", 64'(num_valid), 64'(2'd2));
    chk("part_fill_i0", 64'(instr[0]), 64'(32'hB));
    chk("part_fill_i1", 64'(instr[1]), 64'(32'hC));
    $display("txn stall pc=104 nv=%0d", num_valid);

    // Flush clears all lines
    @(negedge clk); pc_valid = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0; probe = 32'h100; #1;
    chk("flush_probe_100", 64'(probe_hit), 64'(1'b0));

    // LRU: fill 0x000, 0x100, touch 0x000, fill 0x200 -> 0x100 evicted
    fill_block(32'h000, 32'h000, D0, "lru_f000");
    fill_block(32'h100, 32'h100, D1, "lru_f100");
    @(negedge clk); pc = 32'h000; pc_valid = 1'b1; #1;
    chk("lru_touch_nv", 64'(num_valid), 64'(2'd2));
    chk("lru_touch_i0", 64'(instr[0]), 64'(32'h10));
    @(negedge clk); pc_valid = 1'b0;
    fill_block(32'h200, 32'h200, D2, "lru_f200");
    probe = 32'h100; #1;
    chk("lru_evicted_100", 64'(probe_hit), 64'(1'b0));
    probe = 32'h000; #1;
    chk("lru_kept_000", 64'(probe_hit), 64'(1'b1));
    probe = 32'h200; #1;
    chk("lru_kept_200", 64'(probe_hit), 64'(1'b1));

    // Lookup table (cache holds 0x000 and 0x200 in set 0)
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pc = vecs[i].pc; pc_valid = vecs[i].pc_valid; probe = vecs[i].probe;
      #1;
      chk("vec_i0", 64'(instr[0]), 64'(vecs[i].i0));
      chk("vec_i1", 64'(instr[1]), 64'(vecs[i].i1));
      chk("vec_nv", 64'(num_valid), 64'(vecs[i].nv));
      chk("vec_probe", 64'(probe_hit), 64'(vecs[i].ph));
      $display("vec %0d pc=%h v=%0d nv=%0d probe=%0d", i, pc, pc_valid, num_valid, probe_hit);
    end

    // Flush issued in WAIT: the late response is discarded
    @(negedge clk); pc_valid = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    @(negedge clk); pc = 32'h100; pc_valid = 1'b1;
    @(negedge clk); #1;
    chk("fw_req_valid", 64'(req_valid), 64'(1'b1));
    req_ready = 1'b1;
    @(negedge clk); req_ready = 1'b0; pc_valid = 1'b0; flush = 1'b1; #1;
    chk("fw_in_wait", 64'(busy), 64'(1'b1));
    @(negedge clk); flush = 1'b0; #1;
    chk("fw_idle_busy", 64'(busy), 64'(1'b0));
    chk("fw_idle_req", 64'(req_valid), 64'(1'b0));
    rsp_valid = 1'b1; rsp_data = D1;
    @(negedge clk); rsp_valid = 1'b0; pc = 32'h100; pc_valid = 1'b1; probe = 32'h100; #1;
    chk("fw_discard_nv", 64'(num_valid), 64'(2'd0));
    chk("fw_discard_probe", 64'(probe_hit), 64'(1'b0));
    @(negedge clk); #1;
    chk("fw_remiss_req", 64'(req_valid), 64'(1'b1));
    chk("fw_remiss_addr", 64'(req_addr), 64'(32'h100));
    $display("txn flush-in-wait pc=100 req=%0d", req_valid);

    // Flush in REQ abandons the request
    flush = 1'b1; pc_valid = 1'b0;
    @(negedge clk); flush = 1'b0; #1;
    chk("freq_req_drop", 64'(req_valid), 64'(1'b0));
    chk("freq_busy", 64'(busy), 64'(1'b0));
    $display("txn flush-in-req busy=%0d", busy);

`ifdef ICACHE_PREDECODE_EN
    fill_block(32'h400, 32'h400, 64'h00008067_008000EF, "pd_f400");
    @(negedge clk); pc = 32'h400; pc_valid = 1'b1; #1;
    chk("pd_push", 64'(ras_push), 64'(2'b01));
    chk("pd_pop", 64'(ras_pop), 64'(2'b10));
    pc_valid = 1'b0; #1;
    chk("pd_gated_push", 64'(ras_push), 64'(2'b00));
    chk("pd_gated_pop", 64'(ras_pop), 64'(2'b00));
    $display("txn predecode pc=400");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
